// File: rtl/proc_cache_pkg.sv
// rtl/proc_cache_pkg.sv - shared opcodes and default widths for proc_cache
//
// Contents:
//   ADDR_W, DATA_W, INDEX_W  default address, data and index widths
//   opcode_t                 4-bit processor opcode type
//   OP_LOAD, OP_STORE        the two opcodes the cache acts on
package proc_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int INDEX_W = 4;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_LOAD  = 4'b1000;
    localparam opcode_t OP_STORE = 4'b1001;

endpackage

// File: rtl/proc_cache_if.sv
// rtl/proc_cache_if.sv - sequencer-side bus bundle between the sequencer and proc_cache
//
// Signals:
//   address     byte address of the current load/store
//   op          processor opcode
//   input_data  shared bus data (fill data on load, store data on store)
//   rw          bus direction, 1 = memory read (load), 0 = write/idle
//   busy        bus busy; the cache does not write while it is high
//   data        cached word on hit, else 0
//   miss        LOAD lookup missed
// Modports:
//   master      sequencer side (drives address/op/bus, reads data/miss)
//   slave       cache side
interface proc_cache_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();

    logic [ADDR_W-1:0] address;
    logic [3:0]        op;
    logic [DATA_W-1:0] input_data;
    logic              rw;
    logic              busy;
    logic [DATA_W-1:0] data;
    logic              miss;

    modport master (
        output address, op, input_data, rw, busy,
        input  data, miss
    );

    modport slave (
        input  address, op, input_data, rw, busy,
        output data, miss
    );

endinterface

// File: rtl/proc_cache_line_array.sv
// rtl/proc_cache_line_array.sv - valid/tag/data line storage for proc_cache
//
// Ports:
//   clk, reset      clock and synchronous active-high reset (clears valid bits only)
//   rd_index        combinational read index
//   rd_valid        valid bit of the addressed line
//   rd_tag/rd_data  stored tag/data, forced to 0 while the line is invalid
//   wr_en           write the line at wr_index and mark it valid
//   wr_index        write index
//   wr_tag/wr_data  tag and data to store
module cache_line_array #(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    // Reset has priority over a write in the same cycle, so no line can
    // come out of reset already valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag/data arrays are never reset; they are only observed through the
    // valid gating below, so stale or uninitialised contents never leak out.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    always_comb begin
        rd_valid = valid[rd_index];
        rd_tag   = rd_valid ? tag_mem[rd_index]  : '0;
        rd_data  = rd_valid ? data_mem[rd_index] : '0;
    end

endmodule

// File: rtl/proc_cache.sv
// rtl/proc_cache.sv - direct-mapped write-allocate data cache, one word per line
//
// Ports:
//   clk    clock, rising edge
//   reset  synchronous active-high reset; invalidates every line
//   bus    proc_cache_if.slave: address/op/input_data/rw/busy in, data/miss out
//
// Lookup is purely combinational so the sequencer can decide on a memory
// request in the same cycle it presents the address. Loads that miss capture
// the bus read data; stores capture the bus write data and take over the
// line regardless of the tag it held.
module proc_cache #(
    parameter int ADDR_W  = proc_pkg::ADDR_W,
    parameter int DATA_W  = proc_pkg::DATA_W,
    parameter int INDEX_W = proc_pkg::INDEX_W
) (
    input  logic          clk,
    input  logic          reset,
    proc_cache_if.slave   bus
);

    import proc_pkg::*;

    localparam int TAG_W = ADDR_W - INDEX_W;

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    logic [DATA_W-1:0]  line_data;
    logic               hit;
    logic               is_load;
    logic               is_store;
    logic               fill_en;
    logic               store_en;
    logic               wr_en;

    always_comb begin
        index    = bus.address[INDEX_W-1:0];
        tag      = bus.address[ADDR_W-1:INDEX_W];
        is_load  = (bus.op == OP_LOAD);
        is_store = (bus.op == OP_STORE);
        hit      = line_valid && (line_tag == tag);
    end

    // A fill is blocked once the line hits, so each miss is filled once even
    // if the sequencer holds the read for several cycles.
    always_comb begin
        fill_en  = is_load  &&  bus.rw && !bus.busy && !hit;
        store_en = is_store && !bus.rw && !bus.busy;
        wr_en    = fill_en || store_en;
    end

    // data does not depend on op: any opcode presenting a cached address
    // sees the word.
    always_comb begin
        bus.miss = is_load && !hit;
        bus.data = hit ? line_data : '0;
    end

    cache_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_lines (
        .clk      (clk),
        .reset    (reset),
        .rd_index (index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (wr_en),
        .wr_index (index),
        .wr_tag   (tag),
        .wr_data  (bus.input_data)
    );

endmodule

// File: tb/tb_proc_cache.sv
// tb/tb_proc_cache.sv - directed self-checking bench for proc_cache
module tb_proc_cache;

    localparam logic [3:0] LOAD  = 4'b1000;
    localparam logic [3:0] STORE = 4'b1001;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    proc_cache_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    proc_cache dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then leave 1 time unit for the design to settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] addr,
                         input logic [7:0] din, input logic rw, input logic busy);
        bus.op         = op;
        bus.address    = addr;
        bus.input_data = din;
        bus.rw         = rw;
        bus.busy       = busy;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(4'b0000, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        drive(LOAD, 8'h25, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.miss !== 1'b1) begin
            errors++; $display("FAIL reset_miss: got %b want 1", bus.miss);
        end
        checks++;
        if (bus.data !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %h want 00", bus.data);
        end
        drive(4'b0001, 8'h25, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.miss !== 1'b0) begin
            errors++; $display("FAIL nonload_miss: got %b want 0", bus.miss);
        end
        // A non-load opcode with rw=1 must not fill anything.
        drive(4'b0001, 8'h25, 8'hEE, 1'b1, 1'b0);
        tick();
        drive(LOAD, 8'h25, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.miss !== 1'b1 || bus.data !== 8'h00) begin
            errors++; $display("FAIL nonload_nowrite: got miss=%b data=%h want 1/00", bus.miss, bus.data);
        end
    endtask

    task automatic test_fill();
        do_reset();
        drive(LOAD, 8'h25, 8'hA7, 1'b1, 1'b0);
        checks++;
        if (bus.miss !== 1'b1) begin
            errors++; $display("FAIL fill_pre_miss: got %b want 1", bus.miss);
        end
        tick();
        checks++;
        if (bus.miss !== 1'b0 || bus.data !== 8'hA7) begin
            errors++; $display("FAIL fill_hit: got miss=%b data=%h want 0/a7", bus.miss, bus.data);
        end
        drive(LOAD, 8'h25, 8'h11, 1'b1, 1'b0);
        tick();
        checks++;
        if (bus.data !== 8'hA7) begin
            errors++; $display("FAIL fill_no_refill: got %h want a7", bus.data);
        end
        // data is visible regardless of opcode.
        drive(4'b0000, 8'h25, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.data !== 8'hA7 || bus.miss !== 1'b0) begin
            errors++; $display("FAIL data_any_op: got miss=%b data=%h want 0/a7", bus.miss, bus.data);
        end
    endtask

    task automatic test_busy();
        do_reset();
        drive(LOAD, 8'h25, 8'hA7, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.miss !== 1'b1 || bus.data !== 8'h00) begin
                errors++; $display("FAIL busy_block_%0d: got miss=%b data=%h want 1/00", i, bus.miss, bus.data);
            end
        end
        drive(LOAD, 8'h25, 8'hA7, 1'b1, 1'b0);
        tick();
        checks++;
        if (bus.miss !== 1'b0 || bus.data !== 8'hA7) begin
            errors++; $display("FAIL busy_release: got miss=%b data=%h want 0/a7", bus.miss, bus.data);
        end
        // Busy also blocks stores; lookup of the old line stays valid meanwhile.
        drive(STORE, 8'h25, 8'h99, 1'b0, 1'b1);
        tick();
        drive(LOAD, 8'h25, 8'h00, 1'b0, 1'b1);
        checks++;
        if (bus.miss !== 1'b0 || bus.data !== 8'hA7) begin
            errors++; $display("FAIL busy_store_block: got miss=%b data=%h want 0/a7", bus.miss, bus.data);
        end
    endtask

    task automatic test_store_load();
        do_reset();
        drive(STORE, 8'h3C, 8'h5A, 1'b0, 1'b0);
        tick();
        drive(LOAD, 8'h3C, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.miss !== 1'b0 || bus.data !== 8'h5A) begin
            errors++; $display("FAIL store_load: got miss=%b data=%h want 0/5a", bus.miss, bus.data);
        end
        // Store with rw=1 is not a write.
        drive(STORE, 8'h4B, 8'h66, 1'b1, 1'b0);
        tick();
        drive(LOAD, 8'h4B, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.miss !== 1'b1 || bus.data !== 8'h00) begin
            errors++; $display("FAIL store_rw1_nowrite: got miss=%b data=%h want 1/00", bus.miss, bus.data);
        end
        // Store over an existing hit updates the word.
        drive(STORE, 8'h3C, 8'h81, 1'b0, 1'b0);
        tick();
        tick();
        drive(LOAD, 8'h3C, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.miss !== 1'b0 || bus.data !== 8'h81) begin
            errors++; $display("FAIL store_overwrite: got miss=%b data=%h want 0/81", bus.miss, bus.data);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        drive(LOAD, 8'h25, 8'hA7, 1'b1, 1'b0);
        tick();
        drive(STORE, 8'h15, 8'hC3, 1'b0, 1'b0);
        tick();
        drive(LOAD, 8'h25, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.miss !== 1'b1 || bus.data !== 8'h00) begin
            errors++; $display("FAIL conflict_evicted: got miss=%b data=%h want 1/00", bus.miss, bus.data);
        end
        drive(LOAD, 8'h15, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.miss !== 1'b0 || bus.data !== 8'hC3) begin
            errors++; $display("FAIL conflict_new: got miss=%b data=%h want 0/c3", bus.miss, bus.data);
        end
        // Neighbouring index untouched by the conflict.
        drive(LOAD, 8'h16, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.miss !== 1'b1) begin
            errors++; $display("FAIL conflict_neighbour: got miss=%b want 1", bus.miss);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(LOAD, 8'h25, 8'hA7, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        drive(STORE, 8'h3C, 8'h77, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        drive(LOAD, 8'h3C, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.miss !== 1'b1 || bus.data !== 8'h00) begin
            errors++; $display("FAIL reset_beats_store: got miss=%b data=%h want 1/00", bus.miss, bus.data);
        end
        drive(LOAD, 8'h25, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.miss !== 1'b1 || bus.data !== 8'h00) begin
            errors++; $display("FAIL reset_clears_line: got miss=%b data=%h want 1/00", bus.miss, bus.data);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(STORE, 8'(i * 16 + i), 8'(8'h30 + i), 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            drive(LOAD, 8'(i * 16 + i), 8'h00, 1'b0, 1'b0);
            checks++;
            if (bus.miss !== 1'b0 || bus.data !== 8'(8'h30 + i)) begin
                errors++; $display("FAIL b2b_line_%0d: got miss=%b data=%h want 0/%h", i, bus.miss, bus.data, 8'(8'h30 + i));
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        drive(4'b0000, 8'h00, 8'h00, 1'b0, 1'b0);
        test_reset();
        test_fill();
        test_busy();
        test_store_load();
        test_conflict();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/proc_cache.md
Name: proc_cache

Overview:
- Direct-mapped, write-allocate data cache for one processor. It sits between the load/store sequencer and the shared memory bus.
- Lookup is combinational, so the sequencer can decide on a memory request in the same cycle as start.
- Line fills are captured from the bus data during a load transaction that missed.
- Stores write the bus data into the cache, which keeps the cache coherent with memory for this processor.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width per line (one word per line).
- INDEX_W, 4, index bits; 2**INDEX_W lines (16). Tag width = ADDR_W-INDEX_W (4).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- address  input  ADDR_W  byte address for the current load/store.
- op  input  4  processor opcode; 4'b1000=LOAD, 4'b1001=STORE, others ignored.
- input_data  input  DATA_W  shared bus data (memory read data on fill, store data on store).
- rw  input  1  bus direction from sequencer: 1=memory read (load), 0=write/idle.
- busy  input  1  bus busy; no cache write occurs while high.
- data  output  DATA_W  cached word for address on hit, else 0.
- miss  output  1  LOAD lookup missed.

Behaviour:
- Address split: index=address[INDEX_W-1:0], tag=address[ADDR_W-1:INDEX_W].
- Per line storage: valid bit, tag, DATA_W data.
- Reset (sync): all valid bits cleared. Tag/data contents need not be cleared. With no valid lines, miss=1 for any LOAD and data=0.
- hit is combinational: valid[index] && tag_mem[index]==tag.
- miss (combinational) = (op==LOAD) && !hit. miss=0 for all non-LOAD opcodes.
- data (combinational) = hit ? data_mem[index] : 0. This holds regardless of op.
- Fill (posedge):
  - Condition: op==LOAD, rw==1, busy==0, !hit.
  - Action: data_mem[index]<=input_data, tag_mem[index]<=tag, valid[index]<=1.
  - Effect: from the next cycle hit=1, miss=0, data=filled word.
  - Only one fill per miss, since hit blocks further writes.
- Store (posedge):
  - Condition: op==STORE, rw==0, busy==0.
  - Action: data_mem[index]<=input_data, tag_mem[index]<=tag, valid[index]<=1. Conflicting tags are overwritten (write-allocate).
  - Repeating the write while the condition holds is allowed and idempotent.
- Conflict: two addresses with the same index and different tags evict each other. No replacement policy beyond this.
- Simultaneous reset and fill/store: reset wins; no line becomes valid that cycle.
- busy==1 blocks all writes. Lookup outputs remain valid while busy.
- op outside LOAD/STORE: no state change; miss=0.
- No X on outputs after reset. Outputs read tag/data only when the valid bit is set.

Decomposition:
- Shared package proc_pkg holds:
  - opcode constants OP_LOAD=4'b1000 and OP_STORE=4'b1001;
  - ADDR_W and DATA_W defaults.
- One natural sub-module: cache_line_array. It is the valid/tag/data storage with a combinational read port, one synchronous write port, and a synchronous valid clear.
- Hit/miss logic and write-enable decode live in proc_cache.

Test Plan:
- Reset then op=LOAD, address=8'h25 -> miss=1, data=0. Changing op to 4'b0001 -> miss=0.
- Fill: op=LOAD, address=8'h25, rw=1, busy=0, input_data=8'hA7 for one clock -> next cycle miss=0, data=8'hA7. Then input_data=8'h11 with rw=1 -> data stays 8'hA7 (no refill on hit).
- Busy blocks fill: same as the fill case but busy=1 for 3 clocks -> miss stays 1, data=0. Drop busy -> fill happens on the next edge, data=8'hA7.
- Store then load: op=STORE, address=8'h3C, rw=0, busy=0, input_data=8'h5A, one clock. Then op=LOAD, address=8'h3C -> miss=0, data=8'h5A.
- Conflict eviction:
  - Fill 8'h25 with 8'hA7, then store 8'h15 (same index 5) with 8'hC3.
  - LOAD 8'h25 -> miss=1, data=0.
  - LOAD 8'h15 -> miss=0, data=8'hC3.
- Reset mid-operation: assert reset in the same cycle as a store to 8'h3C -> the following LOAD 8'h3C gives miss=1. A previously filled line also reads miss=1 after reset.
